// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared state encoding and sizing constants for the image loader.
package im_loader_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 32 / 8;
  localparam int CHK_W = 8;
endpackage

// File: rtl/im_loader_if.sv
// im_loader_if: byte stream handshake and IM write port.
interface im_loader_if #(parameter int N = 32, parameter int ADDR_W = 5);
  logic byte_valid;
  logic byte_ready;
  logic [7:0] byte_data;
  logic im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [N-1:0] im_wdata;
  modport master(input byte_valid, byte_data, output byte_ready, im_we, im_waddr, im_wdata);
  modport slave(output byte_valid, byte_data, input byte_ready, im_we, im_waddr, im_wdata);
endinterface

// File: rtl/im_word_packer.sv
// im_word_packer: little-endian byte-to-word assembly with running XOR checksum.
module im_word_packer import im_loader_pkg::*; #(parameter int N = BYTES_PER_WORD * 8) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic accept,
  input  logic [7:0] data,
  output logic [N-1:0] word,
  output logic word_full,
  output logic [CHK_W-1:0] chk
);
  localparam int BPW = N / 8;
  localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
  logic [CW-1:0] byte_cnt;
  logic [N-1:0] lanes;
  // word already includes the byte being accepted, so the writer can latch it on the same edge
  for (genvar g = 0; g < BPW; g++) begin : g_lane
    assign word[8*g +: 8] = (accept && byte_cnt == CW'(g)) ? data : lanes[8*g +: 8];
  end
  assign word_full = accept && byte_cnt == CW'(BPW - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      lanes <= '0;
      chk <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      chk <= '0;
    end else if (accept) begin
      lanes <= word;
      chk <= chk ^ data;
      byte_cnt <= word_full ? '0 : byte_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/im_loader.sv
// im_loader: streams a program image into IM and releases the CPU once the checksum verifies.
module im_loader import im_loader_pkg::*; #(
  parameter int N = BYTES_PER_WORD * 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH = 2 ** ADDR_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_start,
  input  logic [ADDR_W:0] load_len,
  im_loader_if.master bus,
  output logic [ADDR_W:0] words_loaded,
  output logic busy,
  output logic done,
  output logic error,
  output logic cpu_hold
);
  state_t state, nxt;
  logic [ADDR_W:0] len, word_cnt;
  logic [N-1:0] word;
  logic [CHK_W-1:0] chk;
  logic word_full, xfer, bad_len, can_start, start_ok;
  assign xfer = bus.byte_valid && bus.byte_ready;
  assign bad_len = load_len == '0 || load_len > (ADDR_W+1)'(DEPTH);
  assign can_start = state == IDLE || state == DONE || state == ERR;
  assign start_ok = load_start && can_start && !bad_len;
  assign words_loaded = word_cnt;
  im_word_packer #(.N(N)) u_packer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(start_ok),
    .accept(xfer && state == RECV),
    .data(bus.byte_data),
    .word(word),
    .word_full(word_full),
    .chk(chk)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (load_start) nxt = bad_len ? ERR : RECV;
      RECV: if (word_full) nxt = WRITE;
      WRITE: nxt = (word_cnt + (ADDR_W+1)'(1) == len) ? CHECK : RECV;
      CHECK: if (xfer) nxt = (bus.byte_data == chk) ? DONE : ERR;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.byte_ready = state == RECV || state == CHECK;
    bus.im_we = state == WRITE;
    busy = state == RECV || state == WRITE || state == CHECK;
    done = state == DONE;
    error = state == ERR;
    cpu_hold = state != DONE;
  end
  // word_cnt is one bit wider than the address so a full-depth load ends at DEPTH, not 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0;
      word_cnt <= '0;
      bus.im_waddr <= '0;
      bus.im_wdata <= '0;
    end else begin
      if (start_ok) begin
        len <= load_len;
        word_cnt <= '0;
      end
      if (state == WRITE) word_cnt <= word_cnt + 1'b1;
      if (state == RECV && word_full) begin
        bus.im_waddr <= word_cnt[ADDR_W-1:0];
        bus.im_wdata <= word;
      end
    end
  end
endmodule
